// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, instruction register, req/ack fetch FSM and next-PC selection.
// Optional misaligned-fetch detection is enabled by defining IFU_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              pc_update,
  input  logic              jump,
  input  logic              is_jr,
  input  logic              beq,
  input  logic              bne,
  input  logic              zero,
  input  logic [31:0]       rs_data,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next, target, branch_off;
  logic [31:0]       instr_next;
  logic              valid_next;
  logic              pend, pend_next;
  logic              misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  logic err_reg, err_next;
  assign misaligned = |pc[1:0];
  assign fetch_err  = err_reg;
  assign imem_addr  = pc;
`else
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
  assign imem_addr  = {pc[ADDR_W-1:2], 2'b00};
`endif

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign imem_req = (state == REQ);
  assign busy     = (state == REQ) | pend;

  // Next-PC priority: JR, then J/JAL, then taken branch, else sequential.
  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump && is_jr)
      target = rs_data;
    else if (jump)
      target = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if ((beq && zero) || (bne && !zero))
      target = pc_plus4 + branch_off;
    else
      target = pc_plus4;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    valid_next = instr_valid;
    pend_next  = pend;
`ifdef IFU_ALIGN_CHECK_EN
    err_next   = err_reg;
`endif
    case (state)
      IDLE: begin
        if (pc_update) begin
          // A fetch requested alongside a PC commit waits one cycle for the new PC.
          pc_next    = target;
          valid_next = 1'b0;
          pend_next  = pend | fetch_start;
        end else if (fetch_start || pend) begin
          pend_next = 1'b0;
          if (misaligned) begin
`ifdef IFU_ALIGN_CHECK_EN
            err_next = 1'b1;
`endif
          end else begin
            valid_next = 1'b0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      pend        <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_valid <= valid_next;
      pend        <= pend_next;
`ifdef IFU_ALIGN_CHECK_EN
      err_reg     <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written
// multi-cycle sequences (wait states, reset abort, alignment).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start, pc_update, jump, is_jr, beq, bne, zero;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [31:0] pc, pc_plus4;
  logic        instr_valid, busy, fetch_err;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_update(pc_update),
    .jump(jump), .is_jr(is_jr), .beq(beq), .bne(bne), .zero(zero), .rs_data(rs_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs, pu, j, jr, beq, bne, z, ack;
    logic [31:0] rs, rdata;
    logic [31:0] e_pc, e_instr;
    logic        e_valid, e_req, e_busy;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_start = 0; pc_update = 0; jump = 0; is_jr = 0;
    beq = 0; bne = 0; zero = 0; rs_data = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cycles;
    // fields: fs pu j jr beq bne z ack | rs rdata | pc instr | valid req busy
    vecs[0]  = '{1,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h0,          32'h0,          0,1,1};
    vecs[1]  = '{0,0,0,0,0,0,0,1, 32'h0,          32'h2008_0005,  32'h0,          32'h2008_0005,  1,0,0};
    vecs[2]  = '{0,1,1,1,0,0,0,0, 32'h100,        32'h0,          32'h100,        32'h2008_0005,  0,0,0};
    vecs[3]  = '{1,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h100,        32'h2008_0005,  0,1,1};
    vecs[4]  = '{0,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h100,        32'h2008_0005,  0,1,1};
    vecs[5]  = '{0,0,0,0,0,0,0,1, 32'h0,          32'h1000_FFFE,  32'h100,        32'h1000_FFFE,  1,0,0};
    vecs[6]  = '{0,1,0,0,1,0,1,0, 32'h0,          32'h0,          32'hFC,         32'h1000_FFFE,  0,0,0};
    vecs[7]  = '{0,1,1,1,0,0,0,0, 32'h100,        32'h0,          32'h100,        32'h1000_FFFE,  0,0,0};
    vecs[8]  = '{0,1,0,0,1,0,0,0, 32'h0,          32'h0,          32'h104,        32'h1000_FFFE,  0,0,0};
    vecs[9]  = '{0,1,0,0,0,1,0,0, 32'h0,          32'h0,          32'h100,        32'h1000_FFFE,  0,0,0};
    vecs[10] = '{0,1,0,0,0,1,1,0, 32'h0,          32'h0,          32'h104,        32'h1000_FFFE,  0,0,0};
    vecs[11] = '{0,1,1,1,0,0,0,0, 32'h1000_0000,  32'h0,          32'h1000_0000,  32'h1000_FFFE,  0,0,0};
    vecs[12] = '{1,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h1000_0000,  32'h1000_FFFE,  0,1,1};
    vecs[13] = '{0,0,0,0,0,0,0,1, 32'h0,          32'h0800_0040,  32'h1000_0000,  32'h0800_0040,  1,0,0};
    vecs[14] = '{0,1,1,0,0,0,0,0, 32'h0,          32'h0,          32'h1000_0100,  32'h0800_0040,  0,0,0};
    vecs[15] = '{0,1,1,1,0,0,0,0, 32'h44,         32'h0,          32'h44,         32'h0800_0040,  0,0,0};
    vecs[16] = '{0,1,1,1,0,0,0,0, 32'hFFFF_FFFC,  32'h0,          32'hFFFF_FFFC,  32'h0800_0040,  0,0,0};
    vecs[17] = '{0,1,0,0,0,0,0,0, 32'h0,          32'h0,          32'h0,          32'h0800_0040,  0,0,0};
    vecs[18] = '{1,1,0,0,0,0,0,0, 32'h0,          32'h0,          32'h4,          32'h0800_0040,  0,0,1};
    vecs[19] = '{0,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h4,          32'h0800_0040,  0,1,1};
    vecs[20] = '{0,0,0,0,0,0,0,1, 32'h0,          32'h1111_1111,  32'h4,          32'h1111_1111,  1,0,0};
    vecs[21] = '{1,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h4,          32'h1111_1111,  0,1,1};
    vecs[22] = '{0,1,1,1,0,0,0,0, 32'h80,         32'h0,          32'h4,          32'h1111_1111,  0,1,1};
    vecs[23] = '{1,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h4,          32'h1111_1111,  0,1,1};
    vecs[24] = '{0,0,0,0,0,0,0,1, 32'h0,          32'h2222_2222,  32'h4,          32'h2222_2222,  1,0,0};
    vecs[25] = '{0,0,0,0,0,0,0,0, 32'h0,          32'h0,          32'h4,          32'h2222_2222,  1,0,0};

    idle_inputs();
    rst_n = 0;
    #12;
    check("rst_pc",    pc, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_req",   {31'b0, imem_req}, 32'h0);
    check("rst_busy",  {31'b0, busy}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_err",   {31'b0, fetch_err}, 32'h0);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      fetch_start = vecs[i].fs; pc_update = vecs[i].pu; jump = vecs[i].j; is_jr = vecs[i].jr;
      beq = vecs[i].beq; bne = vecs[i].bne; zero = vecs[i].z; imem_ack = vecs[i].ack;
      rs_data = vecs[i].rs; imem_rdata = vecs[i].rdata;
      tick();
      idle_inputs();
      $display("vec %0d: pc=%h instr=%h valid=%b req=%b busy=%b", i, pc, instr, instr_valid, imem_req, busy);
      check($sformatf("v%0d_pc", i),    pc, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      check($sformatf("v%0d_op", i),    {26'b0, opcode}, {26'b0, vecs[i].e_instr[31:26]});
      check($sformatf("v%0d_funct", i), {26'b0, funct}, {26'b0, vecs[i].e_instr[5:0]});
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_busy", i),  {31'b0, busy}, {31'b0, vecs[i].e_busy});
      check($sformatf("v%0d_p4", i),    pc_plus4, vecs[i].e_pc + 32'd4);
      if (vecs[i].e_req)
        check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_pc);
    end

    // Three wait states with an extra fetch_start mid-request (pc is 4 here).
    fetch_start = 1;
    tick();
    idle_inputs();
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (imem_req) req_cycles++;
      check($sformatf("wait%0d_addr", k), imem_addr, 32'h4);
      if (k == 1) fetch_start = 1;
      if (k == 3) begin imem_ack = 1; imem_rdata = 32'h3333_3333; end
      tick();
      idle_inputs();
    end
    $display("wait-state fetch: req_cycles=%0d instr=%h valid=%b", req_cycles, instr, instr_valid);
    check("wait_req_cycles", req_cycles, 32'd4);
    check("wait_req_after",  {31'b0, imem_req}, 32'h0);
    check("wait_instr",      instr, 32'h3333_3333);
    check("wait_valid",      {31'b0, instr_valid}, 32'h1);
    tick();
    check("wait_no_refetch", {31'b0, imem_req}, 32'h0);

    // Reset mid-request drops imem_req without a clock; a late ack is ignored.
    fetch_start = 1;
    tick();
    idle_inputs();
    check("abort_req_before", {31'b0, imem_req}, 32'h1);
    #2 rst_n = 0;
    #1;
    $display("reset abort: req=%b busy=%b pc=%h", imem_req, busy, pc);
    check("abort_req",  {31'b0, imem_req}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_pc",   pc, 32'h0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    idle_inputs();
    $display("late ack: valid=%b instr=%h req=%b", instr_valid, instr, imem_req);
    check("late_ack_valid", {31'b0, instr_valid}, 32'h0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_req",   {31'b0, imem_req}, 32'h0);

`ifdef IFU_ALIGN_CHECK_EN
    pc_update = 1; jump = 1; is_jr = 1; rs_data = 32'h2;
    tick();
    idle_inputs();
    fetch_start = 1;
    tick();
    idle_inputs();
    $display("misaligned fetch: err=%b req=%b busy=%b", fetch_err, imem_req, busy);
    check("align_err",  {31'b0, fetch_err}, 32'h1);
    check("align_req",  {31'b0, imem_req}, 32'h0);
    check("align_busy", {31'b0, busy}, 32'h0);
    tick();
    check("align_sticky", {31'b0, fetch_err}, 32'h1);
`else
    check("noalign_err", {31'b0, fetch_err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
